regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 8-entry register file among NREQ requesters using round-robin arbitration.
- Registers the winner's address and data, then drives the one-hot word-enable through the team's 3-to-8 enable decoder.
- Sits between the datapath writers (ALU writeback, load return, debug port) and the register-file storage array.

---
 rtl/rf_arb_pkg.sv | 35 +++
 rtl/regfile_write_arbiter_decoder3_8.sv | 16 +
 rtl/regfile_write_arbiter.sv | 78 +++++++
 tb/tb_regfile_write_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and the round-robin pick helper for the register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned RF_ADDR_W = 3;
  localparam int unsigned RF_NREG   = 8;
  localparam int unsigned MAX_REQ   = 4;
  localparam int unsigned IDX_W     = 2;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [IDX_W-1:0]     rr_idx_t;

  typedef struct packed {
    logic    valid;
    rr_idx_t idx;
  } rr_pick_t;

  // First eligible index searching upward from ptr, wrapping at nreq-1.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] eligible,
                                       input rr_idx_t ptr,
                                       input int unsigned nreq);
    rr_pick_t    res;
    int unsigned cand;
    res = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= nreq) cand = cand - nreq;
      if ((k < nreq) && !res.valid && eligible[IDX_W'(cand)]) begin
        res.valid = 1'b1;
        res.idx   = IDX_W'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_decoder3_8.sv
// 3-to-8 word-enable decoder; output is all zero when en is low.
module decoder3_8
  import rf_arb_pkg::*;
(
  input  rf_addr_t             addr,
  input  logic                 en,
  output logic [RF_NREG-1:0]   onehot
);

  // One-hot decode of the register address, gated by the write strobe.
  always_comb begin
    onehot = '0;
    if (en) onehot = RF_NREG'(1) << addr;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writers.
// Optional macro RF_ZERO_GUARD_EN: a grant to address 0 suppresses the write strobe.
module regfile_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*RF_ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic                     stall,
  output logic [NREQ-1:0]          gnt,
  output logic                     wr_en,
  output rf_addr_t                 wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [RF_NREG-1:0]       wr_onehot,
  output logic                     busy
);

  logic [NREQ-1:0]   eligible;
  rr_idx_t           rr_ptr;
  rr_idx_t           rr_ptr_next;
  rr_pick_t          pick;
  rf_addr_t          win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_write;

  // Mask the current grantee, pick the next winner and mux its payload.
  always_comb begin
    eligible = req & ~gnt;
    pick     = rr_pick(MAX_REQ'(eligible), rr_ptr, NREQ);
    win_addr = '0;
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick.idx == IDX_W'(i)) begin
        win_addr = req_addr[RF_ADDR_W*i +: RF_ADDR_W];
        win_data = req_data[DATA_W*i +: DATA_W];
      end
    end
`ifdef RF_ZERO_GUARD_EN
    win_write = (win_addr != '0);
`else
    win_write = 1'b1;
`endif
    rr_ptr_next = (pick.idx == IDX_W'(NREQ-1)) ? '0 : pick.idx + IDX_W'(1);
    busy        = |eligible;
  end

  // Grant register, write-port payload and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rr_ptr  <= '0;
    end else if (!stall && pick.valid) begin
      gnt     <= NREQ'(1) << pick.idx;
      wr_en   <= win_write;
      wr_addr <= win_addr;
      wr_data <= win_data;
      rr_ptr  <= rr_ptr_next;
    end else begin
      gnt   <= '0;
      wr_en <= 1'b0;
    end
  end

  decoder3_8 u_decoder3_8 (
    .addr   (wr_addr),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues expected writes,
// a negedge monitor pops and compares whenever a grant is presented.
module tb_regfile_write_arbiter;

  localparam int unsigned NREQ   = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] DA = 32'hA0A0_0001;
  localparam logic [31:0] DB = 32'hB0B0_0002;
  localparam logic [31:0] DC = 32'hC0C0_0003;
  localparam logic [31:0] DD = 32'hD0D0_0004;
  localparam logic [31:0] DE = 32'hE0E0_0005;
  localparam logic [31:0] DF = 32'hF0F0_0006;
  localparam logic [31:0] DG = 32'h1234_5678;
  localparam logic [31:0] DH = 32'hDEAD_BEEF;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NREQ-1:0]          req;
  logic [NREQ*3-1:0]        req_addr;
  logic [NREQ*DATA_W-1:0]   req_data;
  logic                     stall;
  logic [NREQ-1:0]          gnt;
  logic                     wr_en;
  logic [2:0]               wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [7:0]               wr_onehot;
  logic                     busy;

  regfile_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .stall     (stall),
    .gnt       (gnt),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_onehot (wr_onehot),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  g;
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    logic [7:0]  oh;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [2:0] g, input logic w, input logic [2:0] a,
                           input logic [31:0] d, input logic [7:0] oh);
    exp_t e;
    e.g = g; e.w = w; e.a = a; e.d = d; e.oh = oh;
    q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [31:0] d);
    req_addr[3*i +: 3]           = a;
    req_data[DATA_W*i +: DATA_W] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_gnt"}, 64'(gnt), 64'd0);
    chk({name, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({name, "_onehot"}, 64'(wr_onehot), 64'd0);
  endtask

  // Monitor: compare every presented grant against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    chk("onehot_popcount", 64'($countones(wr_onehot)), 64'(wr_en));
    if (gnt != '0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got gnt=%b with empty scoreboard at %0t", gnt, $time);
      end else begin
        e = q.pop_front();
        chk("sb_gnt", 64'(gnt), 64'(e.g));
        chk("sb_wr_en", 64'(wr_en), 64'(e.w));
        chk("sb_wr_addr", 64'(wr_addr), 64'(e.a));
        chk("sb_wr_data", 64'(wr_data), 64'(e.d));
        chk("sb_wr_onehot", 64'(wr_onehot), 64'(e.oh));
      end
    end
  end

  initial begin
    reset    = 1'b1;
    stall    = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;

    // Reset held two cycles with all requesters active.
    set_req(0, 3'd1, DA);
    set_req(1, 3'd2, DB);
    set_req(2, 3'd3, DC);
    req = 3'b111;
    tick();
    tick();
    chk_idle("reset");
    chk("reset_wr_addr", 64'(wr_addr), 64'd0);
    chk("reset_wr_data", 64'(wr_data), 64'd0);

    // Round robin from requester 0 after release.
    expect_wr(3'b001, 1'b1, 3'd1, DA, 8'h02);
    expect_wr(3'b010, 1'b1, 3'd2, DB, 8'h04);
    expect_wr(3'b100, 1'b1, 3'd3, DC, 8'h08);
    expect_wr(3'b001, 1'b1, 3'd1, DA, 8'h02);
    reset = 1'b0;
    repeat (4) tick();
    req = '0;
    tick();
    chk_idle("rr_drain");

    // Single requester: granted only every other cycle.
    set_req(1, 3'd5, DD);
    req = 3'b010;
    expect_wr(3'b010, 1'b1, 3'd5, DD, 8'h20);
    expect_wr(3'b010, 1'b1, 3'd5, DD, 8'h20);
    tick();
    chk("single_busy_granted", 64'(busy), 64'd0);
    tick();
    chk("single_gap_gnt", 64'(gnt), 64'd0);
    chk("single_gap_busy", 64'(busy), 64'd1);
    tick();
    tick();
    req = '0;
    tick();

    // Stall blocks grants; release resumes at the next requester in rr order.
    set_req(0, 3'd6, DE);
    set_req(1, 3'd7, DF);
    stall = 1'b1;
    req   = 3'b011;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_idle("stall");
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_hold_addr", 64'(wr_addr), 64'd5);
      chk("stall_hold_data", 64'(wr_data), 64'(DD));
    end
    expect_wr(3'b001, 1'b1, 3'd6, DE, 8'h40);
    expect_wr(3'b010, 1'b1, 3'd7, DF, 8'h80);
    stall = 1'b0;
    tick();
    tick();
    req = '0;
    tick();

    // Reset while gnt[2] is high kills the next write and restarts at 0.
    set_req(2, 3'd4, DG);
    req = 3'b100;
    expect_wr(3'b100, 1'b1, 3'd4, DG, 8'h10);
    tick();
    reset = 1'b1;
    req   = 3'b111;
    tick();
    chk_idle("mid_reset");
    chk("mid_reset_wr_addr", 64'(wr_addr), 64'd0);
    chk("mid_reset_wr_data", 64'(wr_data), 64'd0);
    expect_wr(3'b001, 1'b1, 3'd6, DE, 8'h40);
    reset = 1'b0;
    tick();
    req = '0;
    tick();

    // Write to address 0; pointer still advances past requester 0.
    set_req(0, 3'd0, DH);
    req = 3'b001;
`ifdef RF_ZERO_GUARD_EN
    expect_wr(3'b001, 1'b0, 3'd0, DH, 8'h00);
`else
    expect_wr(3'b001, 1'b1, 3'd0, DH, 8'h01);
`endif
    tick();
    req = '0;
    tick();
    expect_wr(3'b010, 1'b1, 3'd7, DF, 8'h80);
    req = 3'b111;
    tick();
    req = '0;
    tick();
    tick();
    chk_idle("final");

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
